lcd_writer: RTL and testbench

//  HD44780 16x2 character-LCD driver; consumer of score's 32-char ASCII frame.

---
 rtl/lcd_writer.sv | 140 ++++++++++++++
 tb/tb_lcd_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_writer.sv
// lcd_writer: HD44780 16x2 character-LCD driver.
// Runs the power-up wait and the init command sequence, then rewrites DDRAM from a
// 32-byte snapshot of ASCII on each rising UpdateLCD seen while idle.
// Optional build macro: LCD_PENDING_EN -- a request arriving while busy is held
// (one deep) and served as soon as the current activity finishes.
module lcd_writer #(
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_PULSE_CYC = 16,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0][7:0] ASCII,
  input  logic             UpdateLCD,
  output logic             LCDBusy,
  output logic [7:0]       lcd_data,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  output logic             lcd_on,
  output logic             lcd_blon
);
  localparam int M1   = (POWERUP_CYC > EN_PULSE_CYC) ? POWERUP_CYC : EN_PULSE_CYC;
  localparam int M2   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {PWRUP, INIT, IDLE, REFRESH} st_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} ph_t;

  st_t              st, st_n;
  ph_t              ph, ph_n;
  logic [5:0]       idx, idx_n, last_idx;
  logic [CW-1:0]    cnt, cnt_n, hold_last;
  logic [7:0]       data_n;
  logic             rs_n, en_n, busy_n;
  logic             upd_q, rise, start, load;
  logic [31:0][7:0] snap;
  logic [8:0]       nxt_byte;

  // Control characters and DEL would select CGRAM glyphs or garbage; show a blank.
  function automatic logic [7:0] printable(input logic [7:0] c);
    return (c < 8'h20 || c == 8'h7F) ? 8'h20 : c;
  endfunction

  // {rs, data} for write i of the init (refr=0) or refresh (refr=1) sequence.
  function automatic logic [8:0] pick(input logic refr, input logic [5:0] i,
                                      input logic [31:0][7:0] fr);
    logic [4:0] k;
    k = (i < 6'd17) ? 5'(i - 6'd1) : 5'(i - 6'd2);
    if (!refr) begin
      case (i[1:0])
        2'd0:    return 9'h038;
        2'd1:    return 9'h00C;
        2'd2:    return 9'h006;
        default: return 9'h001;
      endcase
    end
    if (i == 6'd0)  return 9'h080;
    if (i == 6'd17) return 9'h0C0;
    return {1'b1, printable(fr[k])};
  endfunction

  assign rise      = UpdateLCD & ~upd_q;
  assign load      = (st == IDLE) && start;
  assign last_idx  = (st == REFRESH) ? 6'd33 : 6'd3;
  assign hold_last = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLR_WAIT_CYC - 1)
                                                    : CW'(CMD_WAIT_CYC - 1);
  assign lcd_rw    = 1'b0;
  assign lcd_on    = 1'b1;
  assign lcd_blon  = 1'b1;

`ifdef LCD_PENDING_EN
  logic pending;
  assign start = rise | pending;
  // Remember one request that arrives while busy; idle consumes it.
  always_ff @(posedge clk or posedge reset)
    if (reset)             pending <= 1'b0;
    else if (st == IDLE)   pending <= 1'b0;
    else if (rise)         pending <= 1'b1;
`else
  assign start = rise;
`endif

  // Next byte to put on the bus once the current HOLD expires.
  always_comb nxt_byte = pick(st == REFRESH, idx + 6'd1, snap);

  // Frame snapshot taken on the edge that starts a refresh.
  always_ff @(posedge clk or posedge reset)
    if (reset)     snap <= '0;
    else if (load) snap <= ASCII;

  // State, counters and registered pin drivers.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= PWRUP;  ph <= SETUP;  idx <= '0;  cnt <= '0;
      lcd_data <= 8'h00;  lcd_rs <= 1'b0;  lcd_en <= 1'b0;  LCDBusy <= 1'b1;
      upd_q <= 1'b0;
    end else begin
      st <= st_n;  ph <= ph_n;  idx <= idx_n;  cnt <= cnt_n;
      lcd_data <= data_n;  lcd_rs <= rs_n;  lcd_en <= en_n;  LCDBusy <= busy_n;
      upd_q <= UpdateLCD;
    end

  // Sequencer: power-up wait, then SETUP/PULSE/HOLD per byte for init and refresh.
  always_comb begin
    st_n = st;  ph_n = ph;  idx_n = idx;  cnt_n = cnt;
    data_n = lcd_data;  rs_n = lcd_rs;  en_n = lcd_en;  busy_n = LCDBusy;
    case (st)
      PWRUP:
        if (cnt == CW'(POWERUP_CYC - 1)) begin
          st_n = INIT;  ph_n = SETUP;  idx_n = '0;  cnt_n = '0;
          {rs_n, data_n} = pick(1'b0, 6'd0, snap);
        end else cnt_n = cnt + 1'b1;
      IDLE:
        if (start) begin
          st_n = REFRESH;  ph_n = SETUP;  idx_n = '0;  cnt_n = '0;
          {rs_n, data_n} = 9'h080;  busy_n = 1'b1;
        end
      default:
        case (ph)
          SETUP: begin ph_n = PULSE;  cnt_n = '0;  en_n = 1'b1; end
          PULSE:
            if (cnt == CW'(EN_PULSE_CYC - 1)) begin
              ph_n = HOLD;  cnt_n = '0;  en_n = 1'b0;
            end else cnt_n = cnt + 1'b1;
          default:
            if (cnt == hold_last) begin
              cnt_n = '0;
              if (idx == last_idx) begin
                st_n = IDLE;  busy_n = 1'b0;
              end else begin
                idx_n = idx + 6'd1;  ph_n = SETUP;  {rs_n, data_n} = nxt_byte;
              end
            end else cnt_n = cnt + 1'b1;
        endcase
    endcase
  end
endmodule

// File: tb/tb_lcd_writer.sv
// tb_lcd_writer: cycle-accurate expectation queue built from the write-timing rules,
// compared against the DUT every cycle, plus directed literal checks.
// Honours LCD_PENDING_EN the same way the design does.
module tb_lcd_writer;
  localparam int PU = 16, EP = 2, CW = 4, CL = 8;
`ifdef LCD_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk = 0, reset = 1, UpdateLCD = 0;
  logic [31:0][7:0] ASCII = '0;
  logic LCDBusy, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0] lcd_data;

  lcd_writer #(.POWERUP_CYC(PU), .EN_PULSE_CYC(EP), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL)) dut (
    .clk(clk), .reset(reset), .ASCII(ASCII), .UpdateLCD(UpdateLCD), .LCDBusy(LCDBusy),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon));

  always #5 clk = ~clk;

  typedef struct packed {logic busy; logic en; logic rs; logic [7:0] data; logic dchk;} rec_t;
  rec_t mq[$];
  rec_t cur;
  logic pend, upd_prev, rise;
  logic [8:0] wr_q[$];
  logic en_prev = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] sane(input logic [7:0] c);
    return (c < 8'h20 || c == 8'h7F) ? 8'h20 : c;
  endfunction

  // One byte on the bus: 1 setup cycle, EP enable cycles, then the hold time.
  function automatic void push_write(input logic rs, input logic [7:0] d);
    int hold;
    hold = (!rs && d == 8'h01) ? CL : CW;
    mq.push_back('{1'b1, 1'b0, rs, d, 1'b1});
    for (int i = 0; i < EP; i++) mq.push_back('{1'b1, 1'b1, rs, d, 1'b1});
    for (int i = 0; i < hold; i++) mq.push_back('{1'b1, 1'b0, rs, d, 1'b1});
  endfunction

  function automatic void load_refresh(input logic [31:0][7:0] fr);
    push_write(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_write(1'b1, sane(fr[i]));
    push_write(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_write(1'b1, sane(fr[i]));
  endfunction

  // Reference model: the value visible after each clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); pend = 0; upd_prev = 0;
      cur = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      for (int i = 0; i < PU - 1; i++) mq.push_back(cur);
      push_write(1'b0, 8'h38); push_write(1'b0, 8'h0C);
      push_write(1'b0, 8'h06); push_write(1'b0, 8'h01);
    end else begin
      rise = UpdateLCD && !upd_prev;
      upd_prev = UpdateLCD;
      if (cur.busy) begin
        if (rise && PEND) pend = 1;
        if (mq.size() > 0) cur = mq.pop_front();
        else begin cur.busy = 0; cur.en = 0; cur.dchk = 0; end
      end else if (rise || pend) begin
        pend = 0;
        load_refresh(ASCII);
        cur = mq.pop_front();
      end
    end
  end

  // Per-cycle compare and write capture.
  initial forever begin
    @(posedge clk); #4;
    chk("ctrl", {LCDBusy, lcd_en, lcd_rw, lcd_on, lcd_blon}, {cur.busy, cur.en, 3'b011});
    if (cur.dchk) chk("rs_data", {lcd_rs, lcd_data}, {cur.rs, cur.data});
    if (lcd_en && !en_prev) wr_q.push_back({lcd_rs, lcd_data});
    en_prev = lcd_en;
  end

  initial begin
    #600000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(); @(posedge clk); #2; endtask
  task automatic pulse(); UpdateLCD = 1; step(); UpdateLCD = 0; endtask

  task automatic wait_idle();
    int n = 0;
    while ((LCDBusy || mq.size() != 0 || pend || cur.busy) && n < 3000) begin step(); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL wait_idle at %0t: got busy expected idle", $time);
    end
    step();
  endtask

  // Release reset and pin the init timing with literal edge counts.
  task automatic init_check();
    int k, en_at, idle_at;
    en_at = -1; idle_at = -1; k = 0;
    reset = 0;
    while (k < 200 && idle_at < 0) begin
      step(); k++;
      if (lcd_en && en_at < 0) en_at = k;
      if (!LCDBusy && idle_at < 0) idle_at = k;
    end
    chk("first_en_edge", en_at, 17);
    chk("init_idle_edge", idle_at, 48);
  endtask

  string s;
  logic [31:0][7:0] fa, fb;
  int n;

  initial begin
    s = "P1: 3  LEVEL 2  P2: 5  HUMAN/AI ";
    step(); step();
    chk("reset_vals", {LCDBusy, lcd_en, lcd_rs, lcd_data}, {1'b1, 1'b0, 1'b0, 8'h00});
    step();
    // Test 1: power-up and init
    wr_q.delete();
    init_check();
    chk("init_writes", wr_q.size(), 4);
    if (wr_q.size() == 4)
      chk("init_bytes", {wr_q[0], wr_q[1], wr_q[2], wr_q[3]}, {9'h038, 9'h00C, 9'h006, 9'h001});
    step(); step();
    // Test 2: one frame, busy length
    for (int i = 0; i < 32; i++) fa[i] = s[i];
    ASCII = fa; wr_q.delete();
    pulse();
    n = 0;
    while (LCDBusy && n < 1000) begin n++; step(); end
    chk("refresh_len", n, 238);
    wait_idle();
    chk("refresh_writes", wr_q.size(), 34);
    if (wr_q.size() == 34)
      for (int k = 0; k < 34; k++)
        chk("frame_byte", wr_q[k], (k == 0) ? 9'h080 : (k == 17) ? 9'h0C0 :
                                   (k < 17) ? {1'b1, fa[k-1]} : {1'b1, fa[k-2]});
    // Test 3: frame changes after snapshot
    wr_q.delete();
    pulse(); step();
    ASCII = {32{8'h41}};
    wait_idle();
    if (wr_q.size() == 34) begin
      chk("snap_r0", wr_q[1], {1'b1, 8'h50});
      chk("snap_r1", wr_q[20], {1'b1, 8'h3A});
    end else chk("snap_writes", wr_q.size(), 34);
    // Test 4: unprintable bytes
    fb = fa; fb[5] = 8'h0A; fb[20] = 8'h7F; ASCII = fb; wr_q.delete();
    pulse(); wait_idle();
    if (wr_q.size() == 34) begin
      chk("ctl_to_space", wr_q[6], 9'h120);
      chk("del_to_space", wr_q[22], 9'h120);
      chk("neighbour", wr_q[5], 9'h133);
    end else chk("sanit_writes", wr_q.size(), 34);
    // Test 5: second request mid-refresh
    for (int i = 0; i < 32; i++) fb[i] = 8'($urandom_range(32, 126));
    ASCII = fa; wr_q.delete();
    pulse();
    repeat (100) step();
    ASCII = fb; pulse();
    wait_idle(); repeat (5) step();
    chk("mid_req_writes", wr_q.size(), PEND ? 68 : 34);
    if (PEND && wr_q.size() == 68) chk("pend_frame", wr_q[35], {1'b1, fb[0]});
    // Random frames, request timing and hold lengths
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) ASCII[i] = 8'($urandom);
      repeat ($urandom_range(0, 20)) step();
      UpdateLCD = 1;
      repeat ($urandom_range(1, 4)) step();
      UpdateLCD = 0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 200)) step();
        for (int i = 0; i < 32; i++) ASCII[i] = 8'($urandom);
        pulse();
      end
      wait_idle();
    end
    // Test 6: reset while enable is high in refresh write 10
    wr_q.delete();
    pulse();
    n = 0;
    while (wr_q.size() < 10 && n < 500) begin step(); n++; end
    chk("w10_en_high", lcd_en, 1'b1);
    reset = 1; #1;
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_busy", LCDBusy, 1'b1);
    chk("rst_data", {lcd_rs, lcd_data}, 9'h000);
    step(); step();
    wr_q.delete();
    init_check();
    repeat (60) step();
    chk("reinit_writes", wr_q.size(), 4);
    if (wr_q.size() > 0) chk("reinit_first", wr_q[0], 9'h038);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
